// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester a packet burst into a single FIFO
// write port, releasing on last beat or after MAXBURST beats.
module fifo_wr_arbiter #(
  parameter  int NREQ     = 4,
  parameter  int DSIZE    = 8,
  parameter  int MAXBURST = 16,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        gnt_id,
  output logic                  busy,
  output logic                  cap_hit
);

  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   last_gnt;
  logic [CW-1:0]    beat_cnt;
  logic             sel_vld;
  logic             sel_last;
  logic [DSIZE-1:0] sel_data;
  logic             cap_at;

  // Lowest rotation distance from last_gnt+1 wins; the previous owner ranks last.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && (((int'(last) + k) % NREQ) == i)) pick = IDW'(i);
      end
    end
    return pick;
  endfunction

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_vld  = req_valid[i];
        sel_last = req_last[i];
        sel_data = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = busy & ~wfull & (gnt_id == IDW'(i));
    end
  end

  assign busy    = (state == BURST);
  assign winc    = busy & sel_vld & ~wfull;
  assign wdata   = busy ? sel_data : '0;
  assign cap_at  = (beat_cnt == CW'(MAXBURST - 1));
  assign cap_hit = winc & ~sel_last & cap_at;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state    <= IDLE;
      last_gnt <= IDW'(NREQ - 1);
      gnt_id   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state    <= BURST;
            gnt_id   <= rr_pick(req_valid, last_gnt);
            beat_cnt <= '0;
          end
        end
        default: begin
          if (winc) begin
            if (sel_last || cap_at) begin
              state    <= IDLE;
              last_gnt <= gnt_id;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus hand-written
// cap-release sequences.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = 32'h13121110;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic        wfull = 1'b0;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  gnt_id;
  logic        busy;
  logic        cap_hit;

  int n_pass = 0;
  int n_total = 0;

  fifo_wr_arbiter dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .gnt_id(gnt_id), .busy(busy), .cap_hit(cap_hit)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic       chk;
    logic       busy;
    logic       winc;
    logic [1:0] gnt;
    logic [3:0] rdy;
    logic [7:0] wd;
    logic       cap;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic f, input logic chk, input logic b, input logic w,
                              input logic [1:0] g, input logic [3:0] r, input logic [7:0] d,
                              input logic c);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.f = f; t.chk = chk;
    t.busy = b; t.winc = w; t.gnt = g; t.rdy = r; t.wd = d; t.cap = c;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f);
    @(negedge wclk);
    wrst = r; req_valid = v; req_last = l; wfull = f;
    #2;
  endtask

  task automatic idle_row(input logic [3:0] v, input logic [3:0] l);
    tbl.push_back(mk(1'b0, v, l, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00, 1'b0));
  endtask

  initial begin
    // Reset, then all four requesting 1-beat packets: grants 0,1,2,3,0
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00, 1'b0));
    idle_row(4'b1111, 4'b1111);
    tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 8'h10, 1'b0));
    idle_row(4'b1111, 4'b1111);
    tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 8'h11, 1'b0));
    idle_row(4'b1111, 4'b1111);
    tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 8'h12, 1'b0));
    idle_row(4'b1111, 4'b1111);
    tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 8'h13, 1'b0));
    idle_row(4'b1111, 4'b1111);
    tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 8'h10, 1'b0));
    idle_row(4'b0000, 4'b0000);
    // Req 1 alone, then req 2 three-beat packet with 0/1 waiting; next grant wraps to 0
    idle_row(4'b0010, 4'b0010);
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 8'h11, 1'b0));
    idle_row(4'b0111, 4'b0000);
    tbl.push_back(mk(1'b0, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 8'h12, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 8'h12, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0111, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 8'h12, 1'b0));
    idle_row(4'b0011, 4'b0011);
    tbl.push_back(mk(1'b0, 4'b0011, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 8'h10, 1'b0));
    idle_row(4'b0000, 4'b0000);
    // Req 1: one beat, valid gap, five full cycles, then last beat
    idle_row(4'b0010, 4'b0000);
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 8'h11, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, 8'h11, 1'b0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0000, 8'h11, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 8'h11, 1'b0));
    idle_row(4'b0000, 4'b0000);
    // Reset during beat 2 of req 3; afterwards req 0 beats req 3
    idle_row(4'b1001, 4'b0000);
    tbl.push_back(mk(1'b0, 4'b1001, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 8'h13, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00, 1'b0));
    idle_row(4'b1001, 4'b0001);
    tbl.push_back(mk(1'b0, 4'b1001, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 8'h10, 1'b0));
    idle_row(4'b0000, 4'b0000);

    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].rst, tbl[n].v, tbl[n].l, tbl[n].f);
      if (tbl[n].chk) begin
        check($sformatf("busy[%0d]", n), 32'(busy), 32'(tbl[n].busy));
        check($sformatf("winc[%0d]", n), 32'(winc), 32'(tbl[n].winc));
        check($sformatf("ready[%0d]", n), 32'(req_ready), 32'(tbl[n].rdy));
        check($sformatf("wdata[%0d]", n), 32'(wdata), 32'(tbl[n].wd));
        check($sformatf("cap_hit[%0d]", n), 32'(cap_hit), 32'(tbl[n].cap));
        if (tbl[n].busy) check($sformatf("gnt_id[%0d]", n), 32'(gnt_id), 32'(tbl[n].gnt));
      end
    end

    // Req 0 streams without last: 16 beats, cap on the 16th, then req 1 wins
    drive(1'b0, 4'b0001, 4'b0000, 1'b0);
    check("cap_arb_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 16; k++) begin
      req_data[7:0] = 8'(k);
      drive(1'b0, 4'b0001, 4'b0000, 1'b0);
      check($sformatf("cap_winc[%0d]", k), 32'(winc), 32'd1);
      check($sformatf("cap_wdata[%0d]", k), 32'(wdata), 32'(k));
      check($sformatf("cap_gnt[%0d]", k), 32'(gnt_id), 32'd0);
      check($sformatf("cap_pulse[%0d]", k), 32'(cap_hit), (k == 15) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 4'b0011, 4'b0000, 1'b0);
    check("cap_rel_busy", 32'(busy), 32'd0);
    check("cap_rel_winc", 32'(winc), 32'd0);
    check("cap_rel_pulse", 32'(cap_hit), 32'd0);
    drive(1'b0, 4'b0011, 4'b0010, 1'b0);
    check("cap_next_gnt", 32'(gnt_id), 32'd1);
    check("cap_next_wdata", 32'(wdata), 32'h11);
    check("cap_next_winc", 32'(winc), 32'd1);

    // Sole requester 1 re-granted; last coincides with the 16th beat so no pulse
    drive(1'b0, 4'b0010, 4'b0000, 1'b0);
    check("co_arb_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 4'b0010, (k == 15) ? 4'b0010 : 4'b0000, 1'b0);
      check($sformatf("co_winc[%0d]", k), 32'(winc), 32'd1);
      check($sformatf("co_gnt[%0d]", k), 32'(gnt_id), 32'd1);
      check($sformatf("co_pulse[%0d]", k), 32'(cap_hit), 32'd0);
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    check("co_rel_busy", 32'(busy), 32'd0);
    check("co_rel_pulse", 32'(cap_hit), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter DSIZE, default 8, giving the data width per beat.
REQ-003 The block SHALL have parameter MAXBURST, default 16, giving the maximum beats per grant before forced release.
REQ-004 The block SHALL have localparam IDW = clog2(NREQ), the width of the grant index.
REQ-005 Port wclk  input  1  Write-domain clock; all logic on rising edge.
REQ-006 Port wrst  input  1  Reset; one clock, synchronous and active-high.
REQ-007 Port req_valid  input  NREQ  Per-requester beat valid.
REQ-008 Port req_data  input  NREQ*DSIZE  Per-requester beat data; requester i uses bits [i*DSIZE +: DSIZE].
REQ-009 Port req_last  input  NREQ  Per-requester last-beat-of-packet flag, qualified by req_valid.
REQ-010 Port req_ready  output  NREQ  Per-requester beat accept.
REQ-011 Port wfull  input  1  FIFO write-side full flag (registered in the FIFO).
REQ-012 Port winc  output  1  FIFO write enable.
REQ-013 Port wdata  output  DSIZE  FIFO write data.
REQ-014 Port gnt_id  output  IDW  Index of the current owner; valid while busy=1.
REQ-015 Port busy  output  1  High in BURST state.
REQ-016 Port cap_hit  output  1  One-cycle pulse when a grant is released by the MAXBURST cap.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-018 In IDLE, when any req_valid bit is 1, the block SHALL select a winner round-robin, searching from (last_gnt+1) mod NREQ upward with wrap, and enter BURST next cycle with gnt_id = winner and beat count = 0.
REQ-019 Arbitration SHALL cost exactly one cycle: no req_ready, no winc in IDLE.
REQ-020 In BURST, req_ready[gnt_id] SHALL equal ~wfull; all other req_ready bits SHALL be 0.
REQ-021 In BURST, winc SHALL equal req_valid[gnt_id] & ~wfull, combinationally, same cycle.
REQ-022 wdata SHALL equal req_data slice gnt_id in BURST and 0 in IDLE.
REQ-023 A beat transfers when winc=1; beat count SHALL then increment by one (width clog2(MAXBURST+1)).
REQ-024 On a transfer with req_last[gnt_id]=1, the block SHALL return to IDLE next cycle and set last_gnt = gnt_id.
REQ-025 On a transfer that makes beat count equal MAXBURST without req_last, the block SHALL return to IDLE, set last_gnt = gnt_id, and pulse cap_hit for that same cycle.
REQ-026 If req_last and the cap coincide on one transfer, the block SHALL release per REQ-024 and cap_hit SHALL stay 0.
REQ-027 While wfull=1 in BURST, the block SHALL hold state, gnt_id and beat count; winc=0.
REQ-028 While req_valid[gnt_id]=0 in BURST, the block SHALL hold the grant indefinitely (no idle timeout).
REQ-029 Requests from non-owners SHALL be ignored until the next IDLE cycle; simultaneous requests are resolved only by REQ-018.
REQ-030 A grantee SHALL NOT be re-granted back-to-back while another requester is valid in the arbitration cycle.

Reset
REQ-031 While wrst=1 at a rising edge: state=IDLE, last_gnt=NREQ-1, gnt_id=0, beat count=0, cap_hit=0.
REQ-032 Resulting outputs SHALL be winc=0, req_ready=0, wdata=0, busy=0; so requester 0 has first priority after reset.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no further winc; the partial packet is not completed.

Verification
REQ-034 Reset, then req_valid=4'b1111, all 1-beat packets, wfull=0 -> grants in order 0,1,2,3,0; one winc per two cycles.
REQ-035 Req 2 sends 3-beat packet (last on beat 3) while req 0 and req 1 stay valid -> winc for 3 consecutive cycles with req 2 data, no other ready, next grant = 3 wraps to 0.
REQ-036 wfull=1 for 5 cycles mid-packet of req 1 -> winc=0, req_ready=0, gnt_id=1 held; resumes on first wfull=0 cycle with no beat lost or duplicated.
REQ-037 Req 0 streams 20 beats without last, MAXBURST=16 -> 16 winc, cap_hit pulse on 16th beat, IDLE, then req 1 granted if valid else req 0 re-granted.
REQ-038 wrst=1 for one cycle during beat 2 of a burst -> next cycle busy=0, winc=0; with req 3 and req 0 valid, req 0 wins.
REQ-039 Scoreboard: FIFO write stream SHALL equal concatenation of accepted beats per requester, in grant order, with packets unsplit except at cap_hit.
